// File: rtl/edge_threshold.sv
// Purpose : masks the border ring of each Sobel-magnitude frame, thresholds interior pixels, counts edges per frame.
// Latency : fixed 2 clocks from in_valid to out_valid for every pixel.
// Backpressure: none; pixels are accepted whenever in_valid is high, idle gaps are allowed.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_valid, sof           pixel qualifier and start-of-frame marker (sof qualified by in_valid)
//   inputPixel, threshold   gradient magnitude and its edge threshold, both sampled on in_valid
//   outputPixel, edge_flag  thresholded/masked pixel and its edge decision (held while out_valid is low)
//   out_valid               outputPixel valid
//   frame_done              one-cycle pulse alongside the last output pixel of a frame
//   edge_count              edge pixels of the last completed frame, held until the next frame_done
module edge_threshold #(
    parameter  int WORD_SIZE = 8,
    parameter  int ROW_SIZE  = 10,
    parameter  int COL_SIZE  = 10,
    parameter  int BORDER    = 1,
    parameter  int BINARY    = 1,
    localparam int CNT_W     = $clog2(ROW_SIZE * COL_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 sof,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic [WORD_SIZE-1:0] threshold,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic                 out_valid,
    output logic                 edge_flag,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     edge_count
);

    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(COL_SIZE);

    // Counter-width constants so every position compare is width-matched.
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI   = CW'(ROW_SIZE - BORDER);
    localparam logic [RW-1:0] ROW_LAST = RW'(COL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
    localparam logic [RW-1:0] ROW_HI   = RW'(COL_SIZE - BORDER);

    // Position of the next expected pixel.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Stage 1 registers.
    logic                 s1_vld;
    logic [WORD_SIZE-1:0] s1_pix;
    logic [WORD_SIZE-1:0] s1_thr;
    logic                 s1_border;
    logic                 s1_last;
    logic                 s1_sof;

    logic [CNT_W-1:0] acc;

    // Position of the pixel being accepted; sof forces it to the frame origin.
    logic [CW-1:0]        cur_col;
    logic [RW-1:0]        cur_row;
    logic [CW-1:0]        nxt_col;
    logic [RW-1:0]        nxt_row;
    logic                 cur_border;
    logic                 cur_last;
    logic                 s2_edge;
    logic [WORD_SIZE-1:0] s2_pix;
    logic [CNT_W-1:0]     acc_sum;

    always_comb begin
        cur_col    = sof ? '0 : col;
        cur_row    = sof ? '0 : row;
        cur_border = (cur_col < COL_LO) || (cur_col >= COL_HI) ||
                     (cur_row < ROW_LO) || (cur_row >= ROW_HI);
        cur_last   = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        nxt_col    = cur_col + CW'(1);
        nxt_row    = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    always_comb begin
        s2_edge = !s1_border && (s1_pix >= s1_thr);
        s2_pix  = '0;
        if (s2_edge) begin
            s2_pix = (BINARY != 0) ? '1 : s1_pix;
        end
        // A sof pixel starts a fresh count: drop whatever the abandoned frame accumulated,
        // but keep the sof pixel's own edge.
        acc_sum = (s1_sof ? '0 : acc) + CNT_W'(s2_edge);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            s1_vld      <= 1'b0;
            s1_pix      <= '0;
            s1_thr      <= '0;
            s1_border   <= 1'b0;
            s1_last     <= 1'b0;
            s1_sof      <= 1'b0;
            acc         <= '0;
            outputPixel <= '0;
            out_valid   <= 1'b0;
            edge_flag   <= 1'b0;
            frame_done  <= 1'b0;
            edge_count  <= '0;
        end else begin
            s1_vld     <= in_valid;
            out_valid  <= s1_vld;
            frame_done <= 1'b0;

            if (in_valid) begin
                col       <= nxt_col;
                row       <= nxt_row;
                s1_pix    <= inputPixel;
                s1_thr    <= threshold;
                s1_border <= cur_border;
                s1_last   <= cur_last;
                s1_sof    <= sof;
            end

            if (s1_vld) begin
                outputPixel <= s2_pix;
                edge_flag   <= s2_edge;
                if (s1_last) begin
                    edge_count <= acc_sum;
                    acc        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_threshold.sv
module tb_edge_threshold;

    localparam int ROW = 10;
    localparam int COLS = 10;
    localparam int B = 1;
    localparam int NPIX = ROW * COLS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] inputPixel = '0;
    logic [7:0] threshold = '0;

    logic [7:0] outputPixel, op_p;
    logic       out_valid, ov_p, edge_flag, ef_p, frame_done, fd_p;
    logic [6:0] edge_count, ec_p;

    edge_threshold #(.WORD_SIZE(8), .ROW_SIZE(ROW), .COL_SIZE(COLS), .BORDER(B), .BINARY(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .sof(sof),
        .inputPixel(inputPixel), .threshold(threshold),
        .outputPixel(outputPixel), .out_valid(out_valid), .edge_flag(edge_flag),
        .frame_done(frame_done), .edge_count(edge_count));

    edge_threshold #(.WORD_SIZE(8), .ROW_SIZE(ROW), .COL_SIZE(COLS), .BORDER(B), .BINARY(0)) dut_p (
        .clock(clock), .reset(reset), .in_valid(in_valid), .sof(sof),
        .inputPixel(inputPixel), .threshold(threshold),
        .outputPixel(op_p), .out_valid(ov_p), .edge_flag(ef_p),
        .frame_done(fd_p), .edge_count(ec_p));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] thr;
        logic [7:0] exp_bin;
        logic [7:0] exp_raw;
        logic       exp_edge;
    } vec_t;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] raw;
        logic       edg;
        logic       done;
        logic [6:0] cnt;
        int         due;
    } exp_t;

    exp_t q[$];
    vec_t tab[8];
    vec_t none;

    int checks = 0;
    int errors = 0;

    // Reference model state: position in frame, running edge total, last reported count.
    int m_pos = 0;
    int m_acc = 0;
    int m_held = 0;

    // Monitor bookkeeping.
    int out_idx = 0;
    int last_done_idx = 0;
    int done_gap = 0;
    int done_cnt = 0;
    logic [7:0] prev_bin = '0;
    logic [7:0] prev_raw = '0;
    logic       prev_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one pixel for one clock and queue what the outputs must show two clocks later.
    task automatic send(input logic [7:0] pix, input logic [7:0] thr, input logic s,
                        input bit use_tab, input vec_t v);
        int r, c;
        bit border, e;
        exp_t x;
        @(negedge clock);
        #1;
        in_valid = 1'b1;
        sof = s;
        inputPixel = pix;
        threshold = thr;
        if (s) begin
            m_pos = 0;
            m_acc = 0;
        end
        r = m_pos / ROW;
        c = m_pos % ROW;
        border = (r < B) || (r >= COLS - B) || (c < B) || (c >= ROW - B);
        e = !border && (pix >= thr);
        x.bin = e ? 8'hFF : 8'h00;
        x.raw = e ? pix : 8'h00;
        x.edg = e;
        if (use_tab && !border) begin
            x.bin = v.exp_bin;
            x.raw = v.exp_raw;
            x.edg = v.exp_edge;
        end
        m_acc += int'(x.edg);
        x.done = (m_pos == NPIX - 1);
        if (x.done) begin
            m_held = m_acc;
            m_acc = 0;
        end
        x.cnt = 7'(m_held);
        x.due = cyc + 2;
        q.push_back(x);
        m_pos = (m_pos + 1) % NPIX;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic frame(input logic [7:0] pix, input logic [7:0] thr, input int max_gap);
        for (int p = 0; p < NPIX; p++) begin
            send(pix, thr, 1'b0, 1'b0, none);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        #1;
        chk(name, q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        m_pos = 0;
        m_acc = 0;
        m_held = 0;
        idle(3);
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_bin = '0;
            prev_raw = '0;
            prev_edge = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("latency_cycle", cyc, x.due);
                chk("outputPixel_bin", outputPixel, x.bin);
                chk("outputPixel_raw", op_p, x.raw);
                chk("edge_flag", edge_flag, x.edg);
                chk("edge_flag_raw", ef_p, x.edg);
                chk("frame_done", frame_done, x.done);
                chk("edge_count", edge_count, x.cnt);
                chk("edge_count_raw", ec_p, x.cnt);
            end
            chk("out_valid_raw", ov_p, 1);
            out_idx++;
            if (frame_done) begin
                done_gap = out_idx - last_done_idx;
                last_done_idx = out_idx;
                done_cnt++;
            end
            prev_bin = outputPixel;
            prev_raw = op_p;
            prev_edge = edge_flag;
        end else begin
            chk("hold_outputPixel", outputPixel, prev_bin);
            chk("hold_outputPixel_raw", op_p, prev_raw);
            chk("hold_edge_flag", edge_flag, prev_edge);
            chk("idle_frame_done", frame_done, 0);
            chk("idle_out_valid_raw", ov_p, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        none = '{8'd0, 8'd0, 8'd0, 8'd0, 1'b0};
        tab[0] = '{8'd49,  8'd50,  8'd0,   8'd0,   1'b0};
        tab[1] = '{8'd50,  8'd50,  8'd255, 8'd50,  1'b1};
        tab[2] = '{8'd51,  8'd50,  8'd255, 8'd51,  1'b1};
        tab[3] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        tab[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1};
        tab[5] = '{8'd254, 8'd255, 8'd0,   8'd0,   1'b0};
        tab[6] = '{8'd0,   8'd1,   8'd0,   8'd0,   1'b0};
        tab[7] = '{8'd128, 8'd127, 8'd255, 8'd128, 1'b1};

        // Reset state.
        idle(2);
        #1;
        chk("rst_outputPixel", outputPixel, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_edge_flag", edge_flag, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_edge_count", edge_count, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;

        // 1: uniform frame, no gaps.
        d0 = done_cnt;
        frame(8'd100, 8'd50, 0);
        drain("t1_drain");
        chk("t1_edge_count", edge_count, 64);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_done_at_100th", done_gap, 100);

        // 2: same frame with random idle gaps.
        frame(8'd100, 8'd50, 3);
        drain("t2_drain");
        chk("t2_edge_count", edge_count, 64);

        // 3: table vectors on interior pixels; border pixels use a plain value.
        begin
            int k;
            k = 0;
            for (int p = 0; p < NPIX; p++) begin
                int r, c;
                r = p / ROW;
                c = p % ROW;
                if (r >= B && r < COLS - B && c >= B && c < ROW - B) begin
                    send(tab[k].pix, tab[k].thr, p == 0, 1'b1, tab[k]);
                    k = (k + 1) % 8;
                end else begin
                    send(8'd100, 8'd50, p == 0, 1'b0, none);
                end
            end
        end
        drain("t3_drain");
        chk("t3_edge_count", edge_count, 40);

        // 4: reset after 37 pixels, then a full frame.
        d0 = done_cnt;
        for (int p = 0; p < 37; p++) send(8'd100, 8'd50, 1'b0, 1'b0, none);
        do_reset();
        idle(1);
        #1;
        chk("t4_rst_edge_count", edge_count, 0);
        chk("t4_rst_out_valid", out_valid, 0);
        frame(8'd100, 8'd50, 0);
        drain("t4_drain");
        chk("t4_edge_count", edge_count, 64);
        chk("t4_done_pulses", done_cnt - d0, 1);

        // 5: sof at pixel 55 abandons the frame.
        d0 = done_cnt;
        for (int p = 0; p < 55; p++) send(8'd100, 8'd50, 1'b0, 1'b0, none);
        send(8'd100, 8'd50, 1'b1, 1'b0, none);
        for (int p = 1; p < NPIX; p++) send(8'd100, 8'd50, 1'b0, 1'b0, none);
        drain("t5_drain");
        chk("t5_done_pulses", done_cnt - d0, 1);
        chk("t5_edge_count", edge_count, 64);

        // 6: back-to-back frames A (all 200) and B (all 0), threshold 10.
        d0 = done_cnt;
        frame(8'd200, 8'd10, 0);
        frame(8'd0, 8'd10, 0);
        drain("t6_drain");
        chk("t6_done_pulses", done_cnt - d0, 2);
        chk("t6_done_gap", done_gap, 100);
        chk("t6_edge_count", edge_count, 0);

        // Random pixels, thresholds, gaps and occasional sof against the model.
        for (int i = 0; i < 400; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 59) == 0), 1'b0, none);
            idle($urandom_range(0, 3));
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
